// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared types, widths and helpers for the rPLL configuration sequencer
package pll_ctrl_pkg;
  localparam int SEL_W = 6;
  localparam int RELOCK_W = 8;
  typedef enum logic [2:0] {RST_HOLD, WAIT_LOCK, STABLE, LOCKED, FAIL} state_e;
  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q, sync_q;
  // Shift the raw level through two flops; both clear on reset so a stale lock is never seen.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  assign q_o = sync_q;
endmodule

// File: rtl/pll_cfg_ctrl.sv
// pll_cfg_ctrl: resets the rPLL, applies dynamic divider codes and qualifies LOCK with timeout and retry
module pll_cfg_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int               RST_CYCLES    = 16,
  parameter int               LOCK_TIMEOUT  = 27000,
  parameter int               STABLE_CYCLES = 256,
  parameter int               MAX_RETRY     = 3,
  parameter logic [SEL_W-1:0] INIT_IDSEL    = '0,
  parameter logic [SEL_W-1:0] INIT_FBDSEL   = '0,
  parameter logic [SEL_W-1:0] INIT_ODSEL    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  input  logic [SEL_W-1:0]    cfg_idsel,
  input  logic [SEL_W-1:0]    cfg_fbdsel,
  input  logic [SEL_W-1:0]    cfg_odsel,
  output logic                cfg_ready,
  input  logic                pll_lock,
  output logic                pll_reset,
  output logic [SEL_W-1:0]    pll_idsel,
  output logic [SEL_W-1:0]    pll_fbdsel,
  output logic [SEL_W-1:0]    pll_odsel,
  output logic                busy,
  output logic                locked,
  output logic                err,
  output logic [RELOCK_W-1:0] relock_cnt
);
  localparam int CW = clog2(((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES) + 1);
  localparam int TW = clog2(LOCK_TIMEOUT + 1);
  localparam int RW = clog2(MAX_RETRY + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO      = TW'(LOCK_TIMEOUT);
  localparam logic [RW-1:0] RMAX     = RW'(MAX_RETRY);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       tmr_q, tmr_d, tmr_inc;
  logic [RW-1:0]       retry_q, retry_d;
  logic [RELOCK_W-1:0] relock_q, relock_d;
  logic [SEL_W-1:0]    idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
  logic                pll_reset_q, pll_reset_d, busy_q, busy_d, locked_q, locked_d;
  logic                err_q, err_d, ready_q, ready_d;
  logic                lock_s, accept;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (pll_lock),
    .q_o (lock_s)
  );

  // Sequencer next state; the lock timer runs through STABLE so a bouncing lock still times out,
  // and an accepted configuration overrides whatever the current state decided.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    retry_d  = retry_q;
    relock_d = relock_q;
    idsel_d  = idsel_q;
    fbdsel_d = fbdsel_q;
    odsel_d  = odsel_q;
    tmr_inc  = (tmr_q == TMO) ? tmr_q : tmr_q + 1'b1;
    accept   = cfg_valid && ready_q;
    case (state_q)
      RST_HOLD: begin
        tmr_d   = '0;
        cnt_d   = (cnt_q == RST_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == RST_LAST) ? WAIT_LOCK : RST_HOLD;
      end
      WAIT_LOCK: begin
        tmr_d = tmr_inc;
        if (lock_s) state_d = STABLE;
        else if (tmr_inc == TMO) begin
          retry_d = retry_q + 1'b1;
          state_d = (retry_q + 1'b1 == RMAX) ? FAIL : RST_HOLD;
        end
      end
      STABLE: begin
        tmr_d = tmr_inc;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      LOCKED: if (!lock_s) begin
        relock_d = (&relock_q) ? relock_q : relock_q + 1'b1;
        retry_d  = '0;
        state_d  = RST_HOLD;
      end
      FAIL: state_d = FAIL;
      default: state_d = RST_HOLD;
    endcase
    if (accept) begin
      state_d  = RST_HOLD;
      cnt_d    = '0;
      retry_d  = '0;
      relock_d = relock_q;
      idsel_d  = cfg_idsel;
      fbdsel_d = cfg_fbdsel;
      odsel_d  = cfg_odsel;
    end
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    pll_reset_d = (state_d == RST_HOLD) || (state_d == FAIL);
    busy_d      = (state_d == RST_HOLD) || (state_d == WAIT_LOCK) || (state_d == STABLE);
    locked_d    = state_d == LOCKED;
    err_d       = state_d == FAIL;
    ready_d     = (state_d == LOCKED) || (state_d == FAIL);
  end

  // State, counters, codes and registered outputs; reset reapplies the INIT codes.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= RST_HOLD;
      cnt_q       <= '0;
      tmr_q       <= '0;
      retry_q     <= '0;
      relock_q    <= '0;
      idsel_q     <= INIT_IDSEL;
      fbdsel_q    <= INIT_FBDSEL;
      odsel_q     <= INIT_ODSEL;
      pll_reset_q <= 1'b1;
      busy_q      <= 1'b1;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      relock_q    <= relock_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
      pll_reset_q <= pll_reset_d;
      busy_q      <= busy_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
    end

  assign cfg_ready  = ready_q;
  assign pll_reset  = pll_reset_q;
  assign pll_idsel  = idsel_q;
  assign pll_fbdsel = fbdsel_q;
  assign pll_odsel  = odsel_q;
  assign busy       = busy_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign relock_cnt = relock_q;
endmodule

// File: tb/tb_pll_cfg_ctrl.sv
// tb_pll_cfg_ctrl: randomized scoreboard bench comparing every output change against a reference model
module tb_pll_cfg_ctrl;
  localparam int RC = 4, TO = 20, SC = 8, MR = 2;
  localparam logic [5:0] I_ID = 6'h3F, I_FB = 6'h3E, I_OD = 6'h30;
  localparam int H = 0, W = 1, Q = 2, L = 3, F = 4;
  localparam logic [30:0] RST_T = {1'b1, I_ID, I_FB, I_OD, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};

  logic clk = 1'b0, rst = 1'b1, cfg_valid = 1'b0, pll_lock = 1'b0;
  logic [5:0] cfg_idsel = '0, cfg_fbdsel = '0, cfg_odsel = '0;
  logic cfg_ready, pll_reset, busy, locked, err;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic [7:0] relock_cnt;

  typedef struct {int c; logic [30:0] v;} exp_t;
  exp_t expq[$];
  string stim_err[$];
  int total = 0, bad = 0, cyc = 0;
  bit done = 0, checked = 0;

  int m_mode, hold_left, waited, run, tries, relock;
  logic m_s1, m_s2;
  logic [5:0] m_id, m_fb, m_od;
  logic [30:0] m_prev;
  int pll_mode = 1, lock_dly = 10, force_low = 0, rel_age = 0;

  pll_cfg_ctrl #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC), .MAX_RETRY(MR),
    .INIT_IDSEL(I_ID), .INIT_FBDSEL(I_FB), .INIT_ODSEL(I_OD)
  ) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel),
    .cfg_odsel(cfg_odsel), .cfg_ready(cfg_ready), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel), .busy(busy),
    .locked(locked), .err(err), .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [30:0] dut_t();
    return {pll_reset, pll_idsel, pll_fbdsel, pll_odsel, busy, locked, err, cfg_ready, relock_cnt};
  endfunction

  function automatic logic [30:0] m_tuple();
    logic r, bz, lk, er, rd;
    r  = (m_mode == H) || (m_mode == F);
    bz = m_mode <= Q;
    lk = m_mode == L;
    er = m_mode == F;
    rd = m_mode >= L;
    return {r, m_id, m_fb, m_od, bz, lk, er, rd, 8'(relock)};
  endfunction

  task automatic note();
    logic [30:0] t;
    t = m_tuple();
    if (t !== m_prev) begin
      expq.push_back('{cyc, t});
      m_prev = t;
    end
  endtask

  task automatic model_reset();
    m_mode = H; hold_left = RC; waited = 0; run = 0; tries = 0; relock = 0;
    m_s1 = 1'b0; m_s2 = 1'b0; m_id = I_ID; m_fb = I_FB; m_od = I_OD;
    note();
  endtask

  // One clock of the reference: hold counts down, waited counts cycles since release,
  // run counts consecutive synced-lock cycles, tries counts timed-out attempts.
  task automatic model_step();
    logic ls;
    ls = m_s2; m_s2 = m_s1; m_s1 = pll_lock;
    if (cfg_valid && m_mode >= L) begin
      m_id = cfg_idsel; m_fb = cfg_fbdsel; m_od = cfg_odsel;
      tries = 0; m_mode = H; hold_left = RC;
    end else if (m_mode == H) begin
      hold_left--;
      if (hold_left == 0) begin m_mode = W; waited = 0; end
    end else if (m_mode == W) begin
      waited++;
      if (ls) begin m_mode = Q; run = 0; end
      else if (waited >= TO) begin
        tries++;
        if (tries == MR) m_mode = F;
        else begin m_mode = H; hold_left = RC; end
      end
    end else if (m_mode == Q) begin
      waited++;
      if (!ls) m_mode = W;
      else begin
        run++;
        if (run == SC) m_mode = L;
      end
    end else if (m_mode == L && !ls) begin
      if (relock < 255) relock++;
      tries = 0; m_mode = H; hold_left = RC;
    end
    note();
  endtask

  task automatic tick();
    logic lk;
    @(posedge clk);
    cyc++;
    if (rst) model_reset(); else model_step();
    rel_age = ((m_mode == H) || (m_mode == F)) ? 0 : rel_age + 1;
    lk = (pll_mode == 1) ? (rel_age >= lock_dly && rel_age > 0) :
         (pll_mode == 2) ? ((rel_age / 5) % 2 == 1) : 1'b0;
    if (force_low > 0) begin lk = 1'b0; force_low--; end
    #1;
    pll_lock = lk;
  endtask

  task automatic send_cfg(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    cfg_valid = 1'b1; cfg_idsel = a; cfg_fbdsel = b; cfg_odsel = c;
    tick();
    cfg_valid = 1'b0; cfg_idsel = 6'($urandom); cfg_fbdsel = 6'($urandom); cfg_odsel = 6'($urandom);
  endtask

  task automatic send_rand();
    send_cfg(6'($urandom), 6'($urandom), 6'($urandom));
  endtask

  task automatic run_until(input int tgt, input int lim, input string nm);
    int n;
    n = 0;
    while (m_mode != tgt && n < lim) begin
      cfg_valid = (m_mode <= Q) && ($urandom_range(0, 3) == 0);
      cfg_idsel = 6'($urandom); cfg_fbdsel = 6'($urandom); cfg_odsel = 6'($urandom);
      tick();
      n++;
    end
    cfg_valid = 1'b0;
    if (m_mode != tgt) stim_err.push_back($sformatf("%s bound expired got_mode=%0d want_mode=%0d", nm, m_mode, tgt));
  endtask

  initial begin
    logic [30:0] prev, cur;
    exp_t e;
    @(negedge clk);
    cur = dut_t();
    total++;
    if (cur !== RST_T) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", cur, RST_T);
    end
    prev = cur;
    forever begin
      @(negedge clk);
      cur = dut_t();
      while (stim_err.size() > 0) begin
        total++; bad++;
        $display("FAIL %s", stim_err.pop_front());
      end
      if (cur !== prev) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL trace cyc=%0d got=%h want=no_change", cyc, cur);
        end else begin
          e = expq.pop_front();
          if (e.c != cyc || e.v !== cur) begin
            bad++;
            $display("FAIL trace cyc=%0d got=%h want=%h at cyc %0d", cyc, cur, e.v, e.c);
          end
        end
        prev = cur;
      end else if (expq.size() > 0 && expq[0].c <= cyc) begin
        total++; bad++;
        e = expq.pop_front();
        $display("FAIL trace cyc=%0d got=no_change(%h) want=%h at cyc %0d", cyc, cur, e.v, e.c);
      end
      if (done && !checked) begin
        total++;
        if (expq.size() != 0) begin
          bad++;
          $display("FAIL leftover got=%0d want=0 pending expectations", expq.size());
        end
        checked = 1;
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    m_prev = RST_T;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    run_until(L, 200, "powerup");
    repeat (4) tick();
    send_cfg(6'h38, 6'h3A, 6'h3C);
    run_until(L, 200, "reconfig");
    pll_mode = 0;
    send_rand();
    run_until(F, 200, "timeout_fail");
    repeat (3) tick();
    pll_mode = 1; lock_dly = 3;
    send_rand();
    run_until(L, 200, "recover");
    pll_mode = 2;
    send_rand();
    run_until(F, 400, "bounce_fail");
    pll_mode = 1;
    send_rand();
    run_until(L, 200, "recover2");
    force_low = 3;
    repeat (8) tick();
    run_until(L, 200, "lock_loss");
    lock_dly = 1;
    repeat (256) begin
      force_low = 1;
      repeat (6) tick();
      run_until(L, 100, "loss_saturate");
    end
    repeat (40) begin
      repeat ($urandom_range(0, 6)) tick();
      case ($urandom_range(0, 2))
        0: force_low = $urandom_range(1, 3);
        1: send_rand();
        default: begin
          force_low = 1;
          repeat ($urandom_range(1, 4)) tick();
          if (m_mode >= L) send_rand();
        end
      endcase
      repeat (8) tick();
      lock_dly = $urandom_range(1, 12);
      run_until(L, 200, "random_mix");
    end
    send_rand();
    run_until(Q, 100, "reach_stable");
    repeat ($urandom_range(0, 4)) tick();
    #2;
    rst = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    run_until(L, 200, "after_rst");
    repeat (4) tick();
    done = 1;
    for (int i = 0; i < 5 && !checked; i++) @(posedge clk);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
